// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit and imem.
// Request is held until ready; ready may coincide with the request cycle.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues one imem read at a time, presents IMcode_F/PC_F,
// flags illegal fetch addresses and applies D-stage redirects on hand-off.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_SIZE  = 32'h0000_4000
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Stall,
    input  logic                Redirect,
    input  logic [31:0]         Redirect_PC,
    fetch_unit_if.master        imem,
    output logic [31:0]         IMcode_F,
    output logic [31:0]         PC_F,
    output logic                ExcAdEL_F,
    output logic                IF_Busy
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   ibuf_q, ibuf_d;

    logic              legal_c;
    logic              valid_c;
    logic              req_c;
    logic [XLEN-1:0]   npc_c;

    // Window check written as offset compare so the upper bound cannot wrap.
    always_comb begin
        legal_c = (pc_q[1:0] == 2'b00) &&
                  (pc_q >= IM_BASE) &&
                  ((pc_q - IM_BASE) < IM_SIZE);
    end

    assign npc_c = Redirect ? Redirect_PC : pc_q + XLEN'(4);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            ibuf_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ibuf_q  <= ibuf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ibuf_d   = ibuf_q;
        req_c    = 1'b0;
        valid_c  = 1'b0;
        IMcode_F = '0;
        IF_Busy  = 1'b0;

        case (state_q)
            S_REQ: begin
                if (legal_c) begin
                    req_c = 1'b1;
                    if (imem.imem_ready) begin
                        valid_c  = 1'b1;
                        IMcode_F = imem.imem_rdata;
                        // Capture so a stalled instruction is never re-read.
                        if (Stall) begin
                            ibuf_d  = imem.imem_rdata;
                            state_d = S_HOLD;
                        end
                    end else begin
                        IF_Busy = 1'b1;
                    end
                end else begin
                    valid_c = 1'b1;
                end
            end
            S_HOLD: begin
                valid_c  = 1'b1;
                IMcode_F = ibuf_q;
                if (!Stall) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (valid_c && !Stall) begin
            pc_d = npc_c;
        end
    end

    assign imem.imem_req  = req_c && !Reset;
    assign imem.imem_addr = {pc_q[XLEN-1:2], 2'b00};
    assign PC_F           = pc_q;
    assign ExcAdEL_F      = !legal_c;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a latency-randomizing imem responder and an
// instruction-level reference model of which PC/word the IF stage must present.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC  = 32'h0000_3000;
    localparam logic [31:0] BASE    = 32'h0000_3000;
    localparam logic [31:0] SIZE    = 32'h0000_4000;
    localparam int unsigned N_RAND  = 3000;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] Redirect_PC = '0;
    logic [31:0] IMcode_F;
    logic [31:0] PC_F;
    logic        ExcAdEL_F;
    logic        IF_Busy;

    fetch_unit_if imem ();

    fetch_unit #(
        .RESET_PC (RST_PC),
        .IM_BASE  (BASE),
        .IM_SIZE  (SIZE)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Stall       (Stall),
        .Redirect    (Redirect),
        .Redirect_PC (Redirect_PC),
        .imem        (imem),
        .IMcode_F    (IMcode_F),
        .PC_F        (PC_F),
        .ExcAdEL_F   (ExcAdEL_F),
        .IF_Busy     (IF_Busy)
    );

    always #5 CLK = ~CLK;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    // imem responder state
    bit          pending = 1'b0;
    int unsigned wait_n  = 0;
    int unsigned req_cnt = 0;

    // reference model: PC to present, and a word already delivered but not yet handed off
    logic [31:0] m_pc   = RST_PC;
    bit          m_got  = 1'b0;
    logic [31:0] m_word = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t pc=%h)", tag, obs, exp, $time, m_pc);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit legal_of(input logic [31:0] a);
        longint unsigned la, lb, lt;
        la = longint'(a);
        lb = longint'(BASE);
        lt = lb + longint'(SIZE);
        return (a % 4 == 0) && (la >= lb) && (la < lt);
    endfunction

    // One clock: drive controls, answer imem, check outputs, advance the model.
    task automatic cycle(input bit rst, input bit st, input bit rd,
                         input logic [31:0] rpc, input bit zero_wait);
        bit          lg, valid, e_req, e_busy;
        logic [31:0] e_code;
        @(posedge CLK);
        #1;
        Reset = rst; Stall = st; Redirect = rd; Redirect_PC = rpc;
        #1;
        if (imem.imem_req) begin
            req_cnt++;
            if (!pending) begin
                pending = 1'b1;
                wait_n  = zero_wait ? 0 : $urandom_range(0, 3);
            end
            if (wait_n == 0) begin
                imem.imem_ready = 1'b1;
                imem.imem_rdata = word_of(imem.imem_addr);
                pending = 1'b0;
            end else begin
                imem.imem_ready = 1'b0;
                imem.imem_rdata = $urandom;
                wait_n--;
            end
        end else begin
            pending = 1'b0;
            imem.imem_ready = 1'b0;
            imem.imem_rdata = $urandom;
        end
        #1;
        if (rst) begin
            check("req_in_reset", 32'(imem.imem_req), 32'd0);
            m_pc  = RST_PC;
            m_got = 1'b0;
        end else begin
            lg = legal_of(m_pc);
            if (!lg) begin
                e_req = 1'b0; e_code = '0; e_busy = 1'b0; valid = 1'b1;
            end else if (m_got) begin
                e_req = 1'b0; e_code = m_word; e_busy = 1'b0; valid = 1'b1;
            end else begin
                e_req  = 1'b1;
                valid  = imem.imem_ready;
                e_busy = !imem.imem_ready;
                e_code = imem.imem_ready ? word_of(m_pc) : 32'd0;
            end
            check("pc_f", PC_F, m_pc);
            check("adel", 32'(ExcAdEL_F), 32'(!lg));
            check("req", 32'(imem.imem_req), 32'(e_req));
            if (e_req) check("addr", imem.imem_addr, m_pc);
            check("imcode", IMcode_F, e_code);
            check("busy", 32'(IF_Busy), 32'(e_busy));
            if (valid && !st) begin
                m_pc  = rd ? rpc : m_pc + 32'd4;
                m_got = 1'b0;
            end else if (valid && lg && !m_got) begin
                m_got  = 1'b1;
                m_word = word_of(m_pc);
            end
        end
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_3102;
            1:       return 32'h0000_7000;
            2:       return 32'hFFFF_FFFC;
            3:       return 32'h0000_6FFC;
            default: return BASE + (32'($urandom_range(0, 32'hFFF)) << 2);
        endcase
    endfunction

    initial begin
        imem.imem_ready = 1'b0;
        imem.imem_rdata = '0;

        // reset, then zero-wait straight-line fetch
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // hold through a stall: exactly one request for the stalled PC
        req_cnt = 0;
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
        check("one_req_in_hold", req_cnt, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // illegal redirect targets
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_3102, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_7000, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b1);

        for (int unsigned i = 0; i < N_RAND; i++) begin
            bit          rst, st, rd;
            logic [31:0] rpc;
            rst = ($urandom_range(0, 99) == 0);
            st  = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 9) < 2);
            rpc = pick_target();
            cycle(rst, st, rd, rpc, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
